vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Pixel-timing generator for the VGA driver. It runs horizontal and vertical position counters at the pixel rate and produces the active-video flag, the pixel coordinates and per-axis set/reset level pairs. Those pairs feed the downstream sync latches that form the hsync and vsync pins (latch output low = sync asserted). It sits directly upstream of those latches and alongside the pixel-data path.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel-rate enable; counters advance only on clk edges where pix_en=1
- hs_set  output  1  high during the horizontal sync interval
- hs_reset  output  1  exact complement of hs_set
- vs_set  output  1  high during the vertical sync interval
- vs_reset  output  1  exact complement of vs_set
- video_on  output  1  high while the position is in the active area
- x  output  10  pixel column; 0 when video_on=0
- y  output  10  pixel row; 0 when video_on=0
- line_start  output  1  one-clk pulse when h advances to 0
- frame_start  output  1  one-clk pulse when (h,v) advances to (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Both totals must be ≤1024. Internal counters h and v are 10 bits.
- On each pix_en=1 edge, h advances by 1.
  - At h=H_TOTAL-1, h wraps to 0 and v advances by 1.
  - At v=V_TOTAL-1 with a line wrap, v wraps to 0.
- Decoding of the new (h,v) value, registered in the same edge that updates the counters so all outputs are mutually aligned with zero skew:
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs_set = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - vs_set = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491
  - hs_reset = !hs_set; vs_reset = !vs_set. The set/reset pair is never 11 or 00.
  - x = video_on ? h : 0; y = video_on ? v : 0
- line_start and frame_start are high for exactly one clk cycle, following the pix_en edge that produced h=0 (resp. h=0,v=0). They are cleared on every other edge, including pix_en=0 edges.
- When pix_en=0, all outputs other than the pulses hold.

## Timing
- Reset has priority over pix_en.
  - Counters are loaded to (H_TOTAL-1, V_TOTAL-1) = (799,524), which is blanking with no sync.
  - Outputs reset to: video_on=0, x=0, y=0, hs_set=0, hs_reset=1, vs_set=0, vs_reset=1, line_start=0, frame_start=0.
- The first pix_en edge after reset release moves to (0,0).
  - video_on=1, x=0, y=0; line_start=1, frame_start=1.
- Latency: outputs reflect the counter value written in the same edge, one clk after the pix_en sample.
- Reset asserted mid-frame re-initialises the next cycle regardless of position. No partial sync pulse persists: hs_set/vs_set are 0 in the cycle after reset.
- Line period = H_TOTAL pix_en edges. Frame period = H_TOTAL*V_TOTAL = 420000 pix_en edges.
- pix_en may follow any pattern. Behaviour is defined purely by the count of pix_en=1 edges.

## Test plan
- Reset, then pix_en=1 constantly -> edge 1: frame_start=1, line_start=1, video_on=1, x=0, y=0. Edge 640: x=639. Edge 641: video_on=0, x=0.
- Same run, horizontal sync -> hs_set rises at edge 657 (h=656) and falls at edge 753 (h=752). hs_reset is the complement on every cycle. line_start repeats every 800 edges.
- Same run, vertical sync -> vs_set=1 for h=0 of line 490 through h=799 of line 491 (1600 edges). video_on=0 for all lines ≥480. The next frame_start comes 420000 edges after the first.
- pix_en toggling 1,0,1,0 -> all periods double (hs_set high for 192 clk). frame_start and line_start stay one clk wide. Outputs hold while pix_en=0.
- Reset asserted at (h=700, v=491), inside both syncs -> the next cycle has all reset values. The next pix_en edge gives (0,0) with frame_start=1.
- Reset and pix_en both high for 3 cycles -> outputs hold reset values throughout. The first pix_en edge after release gives (0,0).

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: h/v position counters with registered decode of
// active video, pixel coordinates, sync set/reset level pairs and line/frame pulses.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hs_set,
    output logic       hs_reset,
    output logic       vs_set,
    output logic       vs_reset,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_hs_set;
    logic          r_hs_reset;
    logic          r_vs_set;
    logic          r_vs_reset;
    logic          r_video_on;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_h_wrap;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_video_nxt;
    logic          w_hs_nxt;
    logic          w_vs_nxt;

    // Next position and its decode, so outputs line up with the counter write.
    always_comb begin
        w_h_wrap = (r_h == CW'(H_TOTAL - 1));
        w_h_nxt  = w_h_wrap ? '0 : r_h + CW'(1);
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = (r_v == CW'(V_TOTAL - 1)) ? '0 : r_v + CW'(1);
        end
        w_video_nxt = (w_h_nxt < CW'(H_ACTIVE)) && (w_v_nxt < CW'(V_ACTIVE));
        w_hs_nxt    = (w_h_nxt >= CW'(HS_FIRST)) && (w_h_nxt <= CW'(HS_LAST));
        w_vs_nxt    = (w_v_nxt >= CW'(VS_FIRST)) && (w_v_nxt <= CW'(VS_LAST));
    end

    // Reset parks at the last blanking position so the first enable lands on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h           <= CW'(H_TOTAL - 1);
            r_v           <= CW'(V_TOTAL - 1);
            r_hs_set      <= 1'b0;
            r_hs_reset    <= 1'b1;
            r_vs_set      <= 1'b0;
            r_vs_reset    <= 1'b1;
            r_video_on    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_en) begin
                r_h           <= w_h_nxt;
                r_v           <= w_v_nxt;
                r_hs_set      <= w_hs_nxt;
                r_hs_reset    <= ~w_hs_nxt;
                r_vs_set      <= w_vs_nxt;
                r_vs_reset    <= ~w_vs_nxt;
                r_video_on    <= w_video_nxt;
                r_x           <= w_video_nxt ? w_h_nxt : '0;
                r_y           <= w_video_nxt ? w_v_nxt : '0;
                r_line_start  <= (w_h_nxt == '0);
                r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
            end
        end
    end

    assign hs_set      = r_hs_set;
    assign hs_reset    = r_hs_reset;
    assign vs_set      = r_vs_set;
    assign vs_reset    = r_vs_reset;
    assign video_on    = r_video_on;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default-timing instance and a shrunken-timing
// instance share stimulus; expected outputs come from an edge-count position model.
module tb_vga_sync_gen;

    localparam int SH_A = 16, SH_F = 4, SH_S = 6, SH_B = 5;
    localparam int SV_A = 10, SV_F = 2, SV_S = 2, SV_B = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;

    logic       d_hs_set, d_hs_reset, d_vs_set, d_vs_reset, d_video_on, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs_set, s_hs_reset, s_vs_set, s_vs_reset, s_video_on, s_ls, s_fs;
    logic [9:0] s_x, s_y;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hs_set(d_hs_set), .hs_reset(d_hs_reset), .vs_set(d_vs_set), .vs_reset(d_vs_reset),
        .video_on(d_video_on), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_sync_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
    ) dut_small (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hs_set(s_hs_set), .hs_reset(s_hs_reset), .vs_set(s_vs_set), .vs_reset(s_vs_reset),
        .video_on(s_video_on), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    logic [26:0] q_def[$];
    logic [26:0] q_small[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    longint      n_edges  = 0;

    // Expected outputs after n enable edges since reset; en_edge marks a counting edge.
    function automatic logic [26:0] model(longint n, bit en_edge,
                                          int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb);
        int     ht = ha + hf + hs + hb;
        int     vt = va + vf + vs + vb;
        int     h, v;
        longint p;
        bit     von, hsy, vsy;
        logic [9:0] ex, ey;
        if (n == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            p = (n - 1) % longint'(ht * vt);
            h = int'(p % longint'(ht));
            v = int'(p / longint'(ht));
        end
        von = (h < ha) && (v < va);
        hsy = (h >= ha + hf) && (h < ha + hf + hs);
        vsy = (v >= va + vf) && (v < va + vf + vs);
        ex  = von ? 10'(h) : 10'd0;
        ey  = von ? 10'(v) : 10'd0;
        return {hsy, !hsy, vsy, !vsy, von, ex, ey,
                en_edge && (h == 0), en_edge && (h == 0) && (v == 0)};
    endfunction

    function automatic bit small_in_both_syncs(longint n);
        logic [26:0] e = model(n, 1'b0, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
        return e[26] && e[24];
    endfunction

    // Drive one cycle and push the response expected after the following rising edge.
    task automatic step(input bit rst, input bit en);
        bit en_edge;
        @(negedge clk);
        reset  = rst;
        pix_en = en;
        en_edge = 1'b0;
        if (rst) begin
            n_edges = 0;
        end else if (en) begin
            n_edges++;
            en_edge = 1'b1;
        end
        q_def.push_back(model(n_edges, en_edge, 640, 16, 96, 48, 480, 10, 2, 33));
        q_small.push_back(model(n_edges, en_edge, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B));
    endtask

    // Monitor: every clock presents a response; compare against the queued expectation.
    always @(posedge clk) begin
        logic [26:0] act, exp_v;
        #1;
        if (q_def.size() > 0) begin
            exp_v = q_def.pop_front();
            act = {d_hs_set, d_hs_reset, d_vs_set, d_vs_reset, d_video_on, d_x, d_y, d_ls, d_fs};
            n_checks++;
            if (act === exp_v) n_pass++;
            else $display("FAIL default_timing t=%0t got=%h want=%h", $time, act, exp_v);
        end
        if (q_small.size() > 0) begin
            exp_v = q_small.pop_front();
            act = {s_hs_set, s_hs_reset, s_vs_set, s_vs_reset, s_video_on, s_x, s_y, s_ls, s_fs};
            n_checks++;
            if (act === exp_v) n_pass++;
            else $display("FAIL small_timing t=%0t got=%h want=%h", $time, act, exp_v);
        end
    end

    initial begin
        int guard;
        // Reset, then continuous enable across several default lines and small frames.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 2500; i++) step(1'b0, 1'b1);

        // Alternating enable doubles every period; pulses stay one clock wide.
        step(1'b1, 1'b0);
        for (int i = 0; i < 1800; i++) step(1'b0, 1'(i % 2 == 0));

        // Reset while the small instance sits inside both sync intervals.
        guard = 0;
        while (!small_in_both_syncs(n_edges) && guard < 2000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            $display("FAIL reach_sync_window got=timeout want=position_in_syncs");
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

        // Reset held together with pix_en, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

        // Random enable pattern with occasional resets.
        for (int i = 0; i < 4000; i++) step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 2) != 0));

        step(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
